// File: rtl/phv_sync_fifo.sv
// phv_sync_fifo
//   Single-clock first-word-fall-through PHV buffer between the last
//   match-action stage and the deparser.
//
//   Ports
//     clk, srst        clock and synchronous active-high reset
//     phv_in           PHV word from the last stage
//     phv_in_valid     write strobe (no upstream backpressure)
//     flush            synchronous discard of all stored entries
//     phv_out          head entry, valid while phv_empty==0
//     phv_rd_en        pop head entry
//     phv_empty        no entries stored
//     phv_full         occupancy == DEPTH
//     phv_nearly_full  occupancy >= AFULL_THRESH
//     phv_count        current occupancy
//     drop_cnt         saturating count of writes dropped while full
//     underflow        sticky flag: pop requested while empty
module phv_sync_fifo #(
  parameter int unsigned PHV_WIDTH    = 1124,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned AFULL_THRESH = 28,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [PHV_WIDTH-1:0] phv_in,
  input  logic                 phv_in_valid,
  input  logic                 flush,
  output logic [PHV_WIDTH-1:0] phv_out,
  input  logic                 phv_rd_en,
  output logic                 phv_empty,
  output logic                 phv_full,
  output logic                 phv_nearly_full,
  output logic [CNT_W-1:0]     phv_count,
  output logic [31:0]          drop_cnt,
  output logic                 underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

  logic [PHV_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  logic             empty_q;
  logic             full_q;
  logic             nfull_q;
  logic [31:0]      drop_cnt_q;
  logic             underflow_q;

  logic rd_accept;
  logic wr_accept;
  logic rd_do;
  logic drop_event;
  logic uf_event;

  // A read frees a slot in the same cycle, so a full FIFO still accepts
  // a write when it is also popped. Flush discards both sides.
  always_comb begin
    rd_accept  = phv_rd_en && !empty_q;
    rd_do      = rd_accept && !flush;
    wr_accept  = phv_in_valid && (!full_q || rd_accept) && !flush;
    drop_event = phv_in_valid && full_q && !rd_accept && !flush;
    uf_event   = phv_rd_en && empty_q && !flush;
  end

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      unique case ({wr_accept, rd_do})
        2'b10:   count_nxt = count_q + CNT_W'(1);
        2'b01:   count_nxt = count_q - CNT_W'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Status flags are registered from next-state occupancy so they change
  // on the same edge as the pointers, keeping outputs free of input paths.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      nfull_q     <= 1'b0;
      drop_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_do)     rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == DEPTH_C);
      nfull_q <= (count_nxt >= AFULL_C);
      if (drop_event && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (uf_event) underflow_q <= 1'b1;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_accept && !srst) mem[wr_ptr] <= phv_in;
  end

  assign phv_out         = mem[rd_ptr];
  assign phv_empty       = empty_q;
  assign phv_full        = full_q;
  assign phv_nearly_full = nfull_q;
  assign phv_count       = count_q;
  assign drop_cnt        = drop_cnt_q;
  assign underflow       = underflow_q;

endmodule

// File: tb/tb_phv_sync_fifo.sv
module tb_phv_sync_fifo;

  localparam int unsigned W     = 64;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AF    = 28;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             srst = 1'b1;
  logic [W-1:0]     phv_in = '0;
  logic             phv_in_valid = 1'b0;
  logic             flush = 1'b0;
  logic [W-1:0]     phv_out;
  logic             phv_rd_en = 1'b0;
  logic             phv_empty;
  logic             phv_full;
  logic             phv_nearly_full;
  logic [CNT_W-1:0] phv_count;
  logic [31:0]      drop_cnt;
  logic             underflow;

  phv_sync_fifo #(
    .PHV_WIDTH   (W),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AF)
  ) dut (
    .clk            (clk),
    .srst           (srst),
    .phv_in         (phv_in),
    .phv_in_valid   (phv_in_valid),
    .flush          (flush),
    .phv_out        (phv_out),
    .phv_rd_en      (phv_rd_en),
    .phv_empty      (phv_empty),
    .phv_full       (phv_full),
    .phv_nearly_full(phv_nearly_full),
    .phv_count      (phv_count),
    .drop_cnt       (drop_cnt),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [W-1:0] q[$];
  logic [31:0] m_drop = '0;
  logic        m_uf = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the scoreboard from the inputs presented
  // before the edge, then compare every output after the edge.
  task automatic tick();
    int  sz;
    bit  rd;
    bit  wr;
    sz = q.size();
    if (srst) begin
      q.delete();
      m_drop = '0;
      m_uf   = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      rd = phv_rd_en && (sz != 0);
      wr = phv_in_valid && ((sz < DEPTH) || rd);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(phv_in);
      if (phv_in_valid && !wr && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
      if (phv_rd_en && sz == 0) m_uf = 1'b1;
    end
    @(posedge clk);
    #1;
    check("count", W'(phv_count), W'(q.size()));
    check("empty", W'(phv_empty), W'(q.size() == 0));
    check("full", W'(phv_full), W'(q.size() == DEPTH));
    check("nearly_full", W'(phv_nearly_full), W'(q.size() >= AF));
    check("drop_cnt", W'(drop_cnt), W'(m_drop));
    check("underflow", W'(underflow), W'(m_uf));
    if (q.size() != 0) check("phv_out", phv_out, q[0]);
  endtask

  task automatic drive(input bit wv, input bit rv, input bit fl);
    phv_in_valid = wv;
    phv_rd_en    = rv;
    flush        = fl;
    phv_in       = {$urandom, $urandom};
  endtask

  initial begin
    // 1: reset, single write, single pop
    drive(0, 0, 0);
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;
    drive(1, 0, 0);
    phv_in = 64'hA5A5_0000_0000_00A1;
    tick();
    check("t1_head", phv_out, 64'hA5A5_0000_0000_00A1);
    drive(0, 1, 0);
    tick();
    check("t1_empty", W'(phv_empty), W'(1));

    // 2: 33 back-to-back writes (last one dropped), then drain across wrap
    for (int i = 0; i < 33; i++) begin
      drive(1, 0, 0);
      tick();
    end
    check("t2_drop", W'(drop_cnt), W'(1));
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0);
      tick();
    end

    // 3: refill, then write+read every cycle while full
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, 0);
      tick();
    end
    check("t3_count", W'(phv_count), W'(32));
    check("t3_drop", W'(drop_cnt), W'(1));
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 0);
      tick();
    end

    // 4: pop on empty with same-cycle write
    drive(1, 1, 0);
    tick();
    check("t4_uf", W'(underflow), W'(1));
    check("t4_count", W'(phv_count), W'(1));
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      tick();
    end

    // 5: fill to 10, flush with a write, then a fresh head
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0);
      tick();
    end
    check("t5_pre", W'(phv_count), W'(10));
    drive(1, 1, 1);
    tick();
    check("t5_flush_empty", W'(phv_empty), W'(1));
    drive(1, 0, 0);
    phv_in = 64'h0000_0000_0000_BEEF;
    tick();
    check("t5_new_head", phv_out, 64'h0000_0000_0000_BEEF);

    // 6: saturate drop counter, then reset mid-burst
    for (int i = 0; i < 31; i++) begin
      drive(1, 0, 0);
      tick();
    end
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt_q;
    m_drop = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0);
      tick();
    end
    check("t6_sat", W'(drop_cnt), W'(32'hFFFF_FFFF));
    drive(1, 1, 0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("t6_rst_count", W'(phv_count), W'(0));
    check("t6_rst_drop", W'(drop_cnt), W'(0));
    check("t6_rst_uf", W'(underflow), W'(0));
    drive(1, 0, 0);
    tick();
    drive(0, 1, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
